// File: rtl/i2s_tx.sv
// i2s_tx: Philips I2S master transmitter with a one-deep sample-pair buffer.
// Core sequencing runs on rising sclk_i; ws_o/sdata_o are retimed on falling
// sclk_i so a receiver sampling on the rising edge sees stable data.
module i2s_tx #(
  parameter int WIDTH = 16,
  parameter int SLOT  = 16
) (
  input  logic             sclk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] left_i,
  input  logic [WIDTH-1:0] right_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             ws_o,
  output logic             sdata_o,
  output logic             frame_o,
  output logic             underrun_o
);

  localparam int          CW      = $clog2(2 * SLOT);
  localparam logic [CW-1:0] LAST  = CW'(2 * SLOT - 1);
  localparam int unsigned SLOT_U  = SLOT;
  localparam int unsigned WIDTH_U = WIDTH;
  localparam bit          PADDED  = (SLOT > WIDTH);

  generate
    if (SLOT < WIDTH) begin : g_slot_chk
      $error("i2s_tx: SLOT must be >= WIDTH");
    end
    if (WIDTH < 2) begin : g_width_chk
      $error("i2s_tx: WIDTH must be >= 2");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             load, wrap, accept;
  logic             buf_full_q;
  logic [WIDTH-1:0] buf_l_q, buf_r_q;
  logic [WIDTH-1:0] frm_l_q, frm_r_q;
  logic             tail_q;
  logic             frame_q, underrun_q;
  logic             core_ws, core_data;
  logic             ws_q, sd_q;

  assign accept     = valid_i && !buf_full_q;
  assign ready_o    = !buf_full_q;
  assign frame_o    = frame_q;
  assign underrun_o = underrun_q;
  assign ws_o       = ws_q;
  assign sdata_o    = sd_q;

  // Next-state, slot counter and frame-load decision
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    wrap    = (state_q == S_RUN) && (cnt_q == LAST);
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (en_i) begin
          state_d = S_RUN;
          load    = 1'b1;
        end
      end
      S_RUN: begin
        if (wrap) begin
          cnt_d = '0;
          if (en_i) load    = 1'b1;
          else      state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge sclk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // One-deep input buffer; an accept on a load edge refills it for the next frame
  always_ff @(posedge sclk_i or negedge rst_i) begin
    if (!rst_i) begin
      buf_full_q <= 1'b0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
    end else if (accept) begin
      buf_full_q <= 1'b1;
      buf_l_q    <= left_i;
      buf_r_q    <= right_i;
    end else if (load) begin
      buf_full_q <= 1'b0;
    end
  end

  // Frame registers and the load/underrun pulses
  always_ff @(posedge sclk_i or negedge rst_i) begin
    if (!rst_i) begin
      frm_l_q    <= '0;
      frm_r_q    <= '0;
      frame_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      frame_q    <= load;
      underrun_q <= load && !buf_full_q;
      if (load) begin
        frm_l_q <= buf_full_q ? buf_l_q : '0;
        frm_r_q <= buf_full_q ? buf_r_q : '0;
      end
    end
  end

  // Right slot's final bit, carried across the wrap into the next cnt=0 period
  always_ff @(posedge sclk_i or negedge rst_i) begin
    if (!rst_i) begin
      tail_q <= 1'b0;
    end else if (state_q == S_IDLE) begin
      tail_q <= 1'b0;
    end else if (wrap) begin
      tail_q <= PADDED ? 1'b0 : frm_r_q[0];
    end
  end

  // Core word select and serial bit for the current count
  always_comb begin
    int unsigned c;
    int unsigned p;
    logic [WIDTH-1:0] word;
    c         = 32'(cnt_q);
    p         = 0;
    word      = '0;
    core_ws   = 1'b0;
    core_data = tail_q;
    if (state_q == S_RUN) begin
      core_ws = (c >= SLOT_U);
      if (c != 0) begin
        if (c <= SLOT_U) begin
          p    = c - 1;
          word = frm_l_q;
        end else begin
          p    = c - SLOT_U - 1;
          word = frm_r_q;
        end
        core_data = (p < WIDTH_U) ?
                    |(word & (WIDTH'(1) << (WIDTH_U - 1 - p))) : 1'b0;
      end
    end
  end

  // Falling-edge retiming of the serial outputs
  always_ff @(negedge sclk_i or negedge rst_i) begin
    if (!rst_i) begin
      ws_q <= 1'b0;
      sd_q <= 1'b0;
    end else begin
      ws_q <= core_ws;
      sd_q <= core_data;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: randomized scoreboard bench for i2s_tx with an I2S receiver monitor.
module tb_i2s_tx;

  localparam int W  = 16;
  localparam int S  = 16;
  localparam int S2 = 24;
  localparam logic [W-1:0] R2C = 16'h5A3C;

  logic sclk = 1'b0;
  always #5 sclk = ~sclk;

  logic         rst_i, en_i, valid_i;
  logic [W-1:0] left_i, right_i;
  logic         ready_o, ws_o, sdata_o, frame_o, underrun_o;

  logic         rst2, en2, v2;
  logic [W-1:0] l2, r2;
  logic         ready2, ws2, sd2, fr2, un2;

  i2s_tx #(.WIDTH(W), .SLOT(S)) u_dut (
    .sclk_i(sclk), .rst_i(rst_i), .en_i(en_i), .left_i(left_i), .right_i(right_i),
    .valid_i(valid_i), .ready_o(ready_o), .ws_o(ws_o), .sdata_o(sdata_o),
    .frame_o(frame_o), .underrun_o(underrun_o)
  );

  i2s_tx #(.WIDTH(W), .SLOT(S2)) u_dut24 (
    .sclk_i(sclk), .rst_i(rst2), .en_i(en2), .left_i(l2), .right_i(r2),
    .valid_i(v2), .ready_o(ready2), .ws_o(ws2), .sdata_o(sd2),
    .frame_o(fr2), .underrun_o(un2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {logic [W-1:0] l; logic [W-1:0] r;} pair_t;
  typedef bit bq_t[$];

  function automatic logic [W-1:0] word_of(input bq_t q, input int slot);
    int n = q.size();
    logic [W-1:0] w = '0;
    if (n < slot) return '0;
    for (int i = 0; i < W; i++) w = {w[W-2:0], q[n-slot+i]};
    return w;
  endfunction

  function automatic bit pad_ok(input bq_t q, input int slot);
    int n = q.size();
    if (n < slot) return 1'b0;
    for (int i = W; i < slot; i++) if (q[n-slot+i]) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- reference model: frame timing and buffer occupancy
  pair_t exp_q[$];
  bit    m_run, m_full, m_frame, m_under, m_fresh;
  int    m_k, m_idle_age;
  pair_t m_buf;

  always @(posedge sclk or negedge rst_i) begin : model
    if (!rst_i) begin
      m_run = 0; m_full = 0; m_frame = 0; m_under = 0; m_fresh = 0;
      m_k = 0; m_idle_age = 1;
      exp_q.delete();
    end else begin
      bit ld, acc;
      if (!m_run && m_idle_age >= 1) begin
        chk("idle_ws", ws_o, 0);
        chk("idle_sdata", sdata_o, 0);
      end
      if (m_run && m_k == 0 && m_fresh) begin
        chk("start_bit", sdata_o, 0);
        chk("start_ws", ws_o, 0);
        m_fresh = 0;
      end
      if (!m_run) m_idle_age++;
      ld = 0;
      if (!m_run) begin
        if (en_i) begin ld = 1; m_run = 1; m_k = 0; m_fresh = 1; end
      end else if (m_k == 2*S-1) begin
        m_k = 0;
        if (en_i) ld = 1;
        else begin m_run = 0; m_idle_age = 0; end
      end else begin
        m_k++;
      end
      acc = valid_i && !m_full;
      if (ld) exp_q.push_back(m_full ? m_buf : pair_t'('0));
      m_frame = ld;
      m_under = ld && !m_full;
      if (acc) begin m_buf = {left_i, right_i}; m_full = 1; end
      else if (ld) m_full = 0;
    end
  end

  // Handshake and pulse checks away from the rising edge
  always @(negedge sclk) begin
    if (rst_i) begin
      chk("ready", ready_o, !m_full);
      chk("frame_pulse", frame_o, m_frame);
      chk("underrun_pulse", underrun_o, m_under);
    end
  end

  // ---------------- I2S receiver monitor (samples on rising sclk)
  bq_t         mq;
  bit          prev_ws, have_l;
  logic [W-1:0] got_l;
  pair_t       e_pair;
  int          frames_seen = 0;

  always @(posedge sclk or negedge rst_i) begin : monitor
    if (!rst_i) begin
      mq.delete(); prev_ws = 0; have_l = 0;
    end else begin
      mq.push_back(sdata_o);
      if (ws_o != prev_ws) begin
        if (!prev_ws) begin
          chk("left_len", mq.size() >= S, 1);
          chk("left_pad", pad_ok(mq, S), 1);
          got_l  = word_of(mq, S);
          have_l = 1;
        end else begin
          chk("right_len", mq.size(), S);
          chk("right_pad", pad_ok(mq, S), 1);
          chk("left_before_right", have_l, 1);
          chk("frame_expected", exp_q.size() > 0, 1);
          if (have_l && exp_q.size() > 0) begin
            e_pair = exp_q.pop_front();
            chk("left_data", got_l, e_pair.l);
            chk("right_data", word_of(mq, S), e_pair.r);
            frames_seen++;
          end
          have_l = 0;
        end
        mq.delete();
      end
      prev_ws = ws_o;
    end
  end

  // Monitor for the SLOT=24 instance: first frame underruns, then FFFF/R2C forever
  bq_t         mq2;
  bit          prev2, hl2;
  logic [W-1:0] gl2;
  int          frames2 = 0;

  always @(posedge sclk) begin : monitor24
    if (rst2) begin
      mq2.push_back(sd2);
      if (ws2 != prev2) begin
        if (!prev2) begin
          chk("s24_left_len", mq2.size() >= S2, 1);
          chk("s24_left_pad", pad_ok(mq2, S2), 1);
          gl2 = word_of(mq2, S2);
          hl2 = 1;
        end else begin
          chk("s24_right_len", mq2.size(), S2);
          chk("s24_right_pad", pad_ok(mq2, S2), 1);
          chk("s24_left_data", gl2, (frames2 == 0) ? 16'h0000 : 16'hFFFF);
          chk("s24_right_data", word_of(mq2, S2), (frames2 == 0) ? 16'h0000 : R2C);
          chk("s24_order", hl2, 1);
          frames2++;
          hl2 = 0;
        end
        mq2.delete();
      end
      prev2 = ws2;
    end
  end

  // ---------------- stimulus
  task automatic push(input logic [W-1:0] l, input logic [W-1:0] r);
    @(negedge sclk);
    valid_i = 1; left_i = l; right_i = r;
    for (int i = 0; i < 8*S; i++) begin
      if (ready_o) begin
        @(negedge sclk);
        valid_i = 0;
        return;
      end
      @(negedge sclk);
    end
    valid_i = 0;
    chk("push_timeout", 0, 1);
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 6*S; i++) begin
      @(negedge sclk);
      if (frame_o) return;
    end
    chk("frame_timeout", 0, 1);
  endtask

  initial begin
    int n;
    bit pv, pr;
    rst_i = 0; en_i = 0; valid_i = 0; left_i = '0; right_i = '0;
    rst2 = 0; en2 = 0; v2 = 0; l2 = 16'hFFFF; r2 = R2C;
    repeat (3) @(negedge sclk);
    #1;
    chk("rst_ready", ready_o, 1);
    chk("rst_ws", ws_o, 0);
    chk("rst_sdata", sdata_o, 0);
    chk("rst_frame", frame_o, 0);
    chk("rst_underrun", underrun_o, 0);
    @(negedge sclk);
    rst_i = 1; rst2 = 1; en2 = 1; v2 = 1;

    // directed pair, then frames with no push (underrun)
    push(16'hA5F0, 16'h0F3C);
    en_i = 1;
    repeat (3*2*S) @(negedge sclk);

    // valid held with a ramp L=n, R=~n
    n = 0; pv = 0; pr = 0;
    for (int cyc = 0; cyc < 8*2*S; cyc++) begin
      @(negedge sclk);
      if (pv && pr) n++;
      left_i = W'(n); right_i = ~W'(n); valid_i = 1;
      pv = 1; pr = ready_o;
    end
    @(negedge sclk) valid_i = 0;

    // random sparse traffic
    for (int cyc = 0; cyc < 6*2*S; cyc++) begin
      @(negedge sclk);
      valid_i = ($urandom_range(0, 3) == 0);
      left_i  = W'($urandom); right_i = W'($urandom);
    end
    @(negedge sclk) valid_i = 0;

    // drop enable mid-frame, then restart
    wait_frame();
    repeat (5) @(negedge sclk);
    en_i = 0;
    repeat (4*S) @(negedge sclk);
    push(W'($urandom), W'($urandom));
    en_i = 1;
    repeat (2*2*S) @(negedge sclk);

    // asynchronous reset at cnt=20 with the buffer full
    wait_frame();
    valid_i = 1; left_i = W'($urandom); right_i = W'($urandom);
    @(negedge sclk) valid_i = 0;
    repeat (19) @(negedge sclk);
    chk("full_before_rst", ready_o, 0);
    #2 rst_i = 0;
    #1;
    chk("arst_ws", ws_o, 0);
    chk("arst_sdata", sdata_o, 0);
    chk("arst_ready", ready_o, 1);
    chk("arst_frame", frame_o, 0);
    repeat (2) @(negedge sclk);
    rst_i = 1;
    repeat (3*2*S) @(negedge sclk);

    // drain
    en_i = 0;
    repeat (4*S) @(negedge sclk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("frames_seen", frames_seen >= 12, 1);
    chk("s24_frames", frames2 >= 4, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
